// File: rtl/iram_uart_loader.sv
// iram_uart_loader: receives a length-prefixed byte image over an 8N1 UART
// line, writes it into IRAM, then releases the cores from reset.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing mod-256 sum byte
// that must match the data bytes before the cores are released.
module iram_uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  BASE_ADDR    = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] ram_address,
  output logic [7:0] ram_data,
  output logic       ram_wren,
  output logic       core_rst,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
`ifdef LOADER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERR
  } ld_state_t;

  logic [1:0]       rx_sync;
  logic             rx_s;
  logic             rx_prev;

  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             start_ok;
  logic             byte_valid;
  logic             frame_err;
  logic             rx_en_c;

  ld_state_t        state;
  logic [8:0]       len;
  logic [8:0]       idx;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       sum;
`endif

  assign rx_s = rx_sync[1];

  // Receiver stops looking for start bits once the load has finished or failed
  assign rx_en_c = (state != ST_DONE) && (state != ST_ERR);

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_s;
    end
  end

  // 8N1 receiver: mid-bit sampling timed from the detected falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      start_ok   <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      start_ok   <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_en_c && rx_prev && !rx_s) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == CNT_W'(HALF_BIT - 1)) begin
            rx_cnt <= '0;
            if (!rx_s) begin
              // still low at mid-bit: a genuine start bit
              rx_state <= RX_BITS;
              rx_bit   <= '0;
              start_ok <= 1'b1;
            end else begin
              // line already back high: treat as a glitch
              rx_state <= RX_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_BITS: begin
          if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s) begin
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Loader FSM with registered IRAM write port and core control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      len         <= '0;
      idx         <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum         <= '0;
`endif
      ram_address <= BASE_ADDR;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      core_rst    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      ram_wren <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state <= ST_LEN;
            busy  <= 1'b1;
          end
        end
        ST_LEN: begin
          if (frame_err) begin
            state    <= ST_ERR;
            error    <= 1'b1;
            busy     <= 1'b0;
            core_rst <= 1'b1;
          end else if (byte_valid) begin
            // a length byte of zero encodes a full 256-byte image
            len   <= (rx_shift == 8'd0) ? 9'd256 : {1'b0, rx_shift};
            idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum   <= '0;
`endif
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (frame_err) begin
            state    <= ST_ERR;
            error    <= 1'b1;
            busy     <= 1'b0;
            core_rst <= 1'b1;
          end else if (byte_valid) begin
            ram_wren    <= 1'b1;
            ram_data    <= rx_shift;
            ram_address <= BASE_ADDR + idx[7:0];
            idx         <= idx + 9'd1;
`ifdef LOADER_CHECKSUM_EN
            sum         <= sum + rx_shift;
`endif
          end else if (idx == len) begin
            // leave only after the final write pulse has been issued in DATA
`ifdef LOADER_CHECKSUM_EN
            state    <= ST_CSUM;
`else
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            core_rst <= 1'b0;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (frame_err) begin
            state    <= ST_ERR;
            error    <= 1'b1;
            busy     <= 1'b0;
            core_rst <= 1'b1;
          end else if (byte_valid) begin
            if (rx_shift == sum) begin
              state    <= ST_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state    <= ST_ERR;
              error    <= 1'b1;
              busy     <= 1'b0;
              core_rst <= 1'b1;
            end
          end
        end
`endif
        ST_DONE: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          core_rst <= 1'b0;
        end
        ST_ERR: begin
          busy     <= 1'b0;
          error    <= 1'b1;
          core_rst <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
